rv_iommu_pte_fetch: RTL and testbench
=====================================

Name: rv_iommu_pte_fetch

Overview:
Single-outstanding PTE fetch engine between the page-table walker FSM and the IOMMU load/store port arbiter. Accepts a PTE physical address plus requester ID and issues an 8-byte LOAD on the arbiter request port with a rotating 2-bit tag. Consumes the 512-bit line returned by the arbiter, extracts the addressed 64-bit PTE, classifies faults and returns one response per request. Drops late or stale data returns and bounds the wait with a timeout.

Parameters:
ID_W, 4, width of requester ID carried request->response
TIMEOUT_CYC, 1024, cycles in WAIT before timeout completion (must be >= 2)
STALE_W, 8, width of saturating stale-return counter

Ports:
clk  in  1  clock
rst_n  in  1  reset, active-low
req_pte_addr_i  in  46  PTE physical address
req_id_i  in  ID_W  requester ID
req_irdy_i  in  1  request valid
req_trdy_o  out  1  request ready
rsp_pte_o  out  64  fetched PTE (0 on any fault)
rsp_id_o  out  ID_W  echoed requester ID
rsp_fault_o  out  2  PTE_OK / PTE_ACC_FAULT / PTE_POISON / PTE_TIMEOUT
rsp_irdy_o  out  1  response valid
rsp_trdy_i  in  1  response ready
ls_addr_o  out  46  to arbiter w_ls_addr_i
ls_op_o  out  2  to arbiter w_ls_op_i, always LS_OP_LOAD
ls_tag_o  out  2  to arbiter w_ls_tag_i
ls_size_o  out  7  to arbiter w_ls_size_i, always 7'd8
ls_req_irdy_o  out  1  load request valid
ls_req_trdy_i  in  1  load request accepted
ld_data_i  in  512  returned line
ld_acc_fault_i  in  1  access fault on return
ld_poison_i  in  1  poisoned data on return
ld_tag_i  in  2  tag of return
ld_data_irdy_i  in  1  return valid
ld_data_trdy_o  out  1  return ready
stale_cnt_o  out  STALE_W  count of dropped returns

Behaviour:
- Clock and reset: one clock clk; rst_n synchronous, active-low. All state is updated only on posedge clk.
- Reset values:
  - state=IDLE, cur_tag=0, timer=0, stale_cnt=0.
  - All outputs 0, except ls_op_o=LS_OP_LOAD and ls_size_o=8 (constants).
- Handshakes: a transfer occurs on the cycle where irdy&&trdy are both high at posedge. An irdy, once raised, stays high with stable payload until the transfer.
- FSM:
  - IDLE: req_trdy_o=1. On accept, capture addr with bits [2:0] forced to 0, capture id -> REQ.
  - REQ: ls_req_irdy_o=1, ls_addr_o=captured addr, ls_tag_o=cur_tag. On ls_req_trdy_i -> WAIT, timer<=0.
  - WAIT: ld_data_trdy_o=1, timer increments each cycle.
    - Return with ld_tag_i==cur_tag -> capture result -> RSP.
    - Return with mismatched tag -> drop, stale_cnt saturating +1, remain in WAIT.
    - timer==TIMEOUT_CYC-1 with no matching return that cycle -> RSP with fault=PTE_TIMEOUT.
    - Matching return in the same cycle as timeout: the return wins.
  - RSP: rsp_irdy_o=1 with registered pte/id/fault. On rsp_trdy_i -> IDLE, cur_tag<=cur_tag+1 (mod 4, also after timeout, so a late return becomes stale).
- ld_data_trdy_o=1 also in IDLE, REQ and RSP, so returns are never back-pressured. Any return outside WAIT is counted stale and dropped.
- Result extraction: pte = ld_data_i[addr[5:3]*64 +: 64].
- Fault priority: acc_fault > poison > OK. rsp_pte_o=0 whenever fault != PTE_OK.
- Latency: request accept -> ls_req_irdy_o high on the next cycle. Matching return -> rsp_irdy_o high on the next cycle.
- Reset mid-operation: FSM returns to IDLE, the outstanding load is abandoned, cur_tag=0, no response is issued.

Decomposition:
- Shared package rv_iommu_pkg:
  - LS_OP_LOAD/STORE/AMO encodings (2-bit).
  - pte_fault_e enum: OK=0, ACC_FAULT=1, POISON=2, TIMEOUT=3.
  - pte_fetch_state_e.
  - PTE_BYTES=8.
- Optional sub-module rv_iommu_line_sel: 512->64 word select by addr[5:3]; otherwise a single module.

Test Plan:
- Req addr 46'h1000, id 3; arbiter returns tag 0, line word0=64'h2001 -> rsp_pte=64'h2001, id=3, fault=OK, ls_tag_o=0, ls_size_o=8.
- Req addr 46'h3048 (word 1), line word1=64'h4001 -> rsp_pte=64'h4001; next request issues ls_tag_o=1.
- Return with ld_acc_fault_i=1 and ld_poison_i=1 -> fault=ACC_FAULT, rsp_pte=0; poison only -> fault=POISON.
- No return for TIMEOUT_CYC cycles -> fault=TIMEOUT. Late return with the old tag, arriving after the next request has issued, -> dropped, stale_cnt_o=1, and the new request completes normally.
- Hold rsp_trdy_i=0 for 5 cycles -> rsp_irdy_o held with stable payload, req_trdy_o=0 throughout.
- Assert rst_n=0 for one cycle while in WAIT -> next cycle all outputs at reset values, tag restarts at 0.

Source files
------------

// File: rtl/rv_iommu_pkg.sv
// Shared IOMMU load/store opcodes, PTE fault codes and fetch-engine state encoding.
package rv_iommu_pkg;

  localparam logic [1:0] LS_OP_LOAD  = 2'd1;
  localparam logic [1:0] LS_OP_STORE = 2'd2;
  localparam logic [1:0] LS_OP_AMO   = 2'd3;

  localparam int PTE_BYTES = 8;

  typedef enum logic [1:0] {
    PTE_OK        = 2'd0,
    PTE_ACC_FAULT = 2'd1,
    PTE_POISON    = 2'd2,
    PTE_TIMEOUT   = 2'd3
  } pte_fault_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RSP  = 2'd3
  } pte_fetch_state_e;

endpackage

// File: rtl/rv_iommu_line_sel.sv
// Picks one 64-bit PTE out of a 512-bit cache line by doubleword index.
module rv_iommu_line_sel (
  input  logic [511:0] i_line,
  input  logic [2:0]   i_sel,
  output logic [63:0]  o_word
);

  assign o_word = i_line[{i_sel, 6'b0} +: 64];

endmodule

// File: rtl/rv_iommu_pte_fetch.sv
// Single-outstanding PTE fetch: issues a tagged 8-byte load, matches the tagged
// return, classifies faults, and bounds the wait with a timeout.
module rv_iommu_pte_fetch
  import rv_iommu_pkg::*;
#(
  parameter int ID_W        = 4,
  parameter int TIMEOUT_CYC = 1024,
  parameter int STALE_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [45:0]        req_pte_addr_i,
  input  logic [ID_W-1:0]    req_id_i,
  input  logic               req_irdy_i,
  output logic               req_trdy_o,
  output logic [63:0]        rsp_pte_o,
  output logic [ID_W-1:0]    rsp_id_o,
  output logic [1:0]         rsp_fault_o,
  output logic               rsp_irdy_o,
  input  logic               rsp_trdy_i,
  output logic [45:0]        ls_addr_o,
  output logic [1:0]         ls_op_o,
  output logic [1:0]         ls_tag_o,
  output logic [6:0]         ls_size_o,
  output logic               ls_req_irdy_o,
  input  logic               ls_req_trdy_i,
  input  logic [511:0]       ld_data_i,
  input  logic               ld_acc_fault_i,
  input  logic               ld_poison_i,
  input  logic [1:0]         ld_tag_i,
  input  logic               ld_data_irdy_i,
  output logic               ld_data_trdy_o,
  output logic [STALE_W-1:0] stale_cnt_o
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  pte_fetch_state_e   r_state;
  logic [1:0]         r_cur_tag;
  logic [TMR_W-1:0]   r_timer;
  logic [STALE_W-1:0] r_stale_cnt;
  logic               r_req_trdy, r_ls_req_irdy, r_ld_trdy, r_rsp_irdy;
  logic [45:0]        r_ls_addr;
  logic [ID_W-1:0]    r_id, r_rsp_id;
  logic [63:0]        r_rsp_pte;
  pte_fault_e         r_rsp_fault;

  logic [63:0] w_word;
  logic        w_ret, w_hit, w_stale;
  pte_fault_e  w_fault;

  rv_iommu_line_sel u_line_sel (
    .i_line (ld_data_i),
    .i_sel  (r_ls_addr[5:3]),
    .o_word (w_word)
  );

  // Only a return carrying the current tag while waiting counts; all others are dropped.
  assign w_ret   = ld_data_irdy_i && r_ld_trdy;
  assign w_hit   = w_ret && (r_state == ST_WAIT) && (ld_tag_i == r_cur_tag);
  assign w_stale = w_ret && !w_hit;
  assign w_fault = ld_acc_fault_i ? PTE_ACC_FAULT :
                   ld_poison_i    ? PTE_POISON    : PTE_OK;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cur_tag     <= 2'd0;
      r_timer       <= '0;
      r_stale_cnt   <= '0;
      r_req_trdy    <= 1'b0;
      r_ls_req_irdy <= 1'b0;
      r_ld_trdy     <= 1'b0;
      r_rsp_irdy    <= 1'b0;
      r_ls_addr     <= '0;
      r_id          <= '0;
      r_rsp_id      <= '0;
      r_rsp_pte     <= '0;
      r_rsp_fault   <= PTE_OK;
    end else begin
      r_ld_trdy <= 1'b1;
      if (w_stale && (r_stale_cnt != {STALE_W{1'b1}}))
        r_stale_cnt <= r_stale_cnt + 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (r_req_trdy && req_irdy_i) begin
            r_ls_addr     <= req_pte_addr_i & ~46'h7;
            r_id          <= req_id_i;
            r_req_trdy    <= 1'b0;
            r_ls_req_irdy <= 1'b1;
            r_state       <= ST_REQ;
          end else begin
            r_req_trdy <= 1'b1;
          end
        end
        ST_REQ: begin
          if (ls_req_trdy_i) begin
            r_ls_req_irdy <= 1'b0;
            r_timer       <= '0;
            r_state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_timer <= r_timer + 1'b1;
          if (w_hit) begin
            r_rsp_fault <= w_fault;
            r_rsp_pte   <= (w_fault == PTE_OK) ? w_word : 64'd0;
            r_rsp_id    <= r_id;
            r_rsp_irdy  <= 1'b1;
            r_state     <= ST_RSP;
          end else if (r_timer == TMR_LAST) begin
            r_rsp_fault <= PTE_TIMEOUT;
            r_rsp_pte   <= 64'd0;
            r_rsp_id    <= r_id;
            r_rsp_irdy  <= 1'b1;
            r_state     <= ST_RSP;
          end
        end
        ST_RSP: begin
          // Tag advances even after a timeout so a late return for it reads as stale.
          if (rsp_trdy_i) begin
            r_rsp_irdy <= 1'b0;
            r_req_trdy <= 1'b1;
            r_cur_tag  <= r_cur_tag + 2'd1;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_trdy_o     = r_req_trdy;
  assign rsp_pte_o      = r_rsp_pte;
  assign rsp_id_o       = r_rsp_id;
  assign rsp_fault_o    = r_rsp_fault;
  assign rsp_irdy_o     = r_rsp_irdy;
  assign ls_addr_o      = r_ls_addr;
  assign ls_op_o        = LS_OP_LOAD;
  assign ls_tag_o       = r_cur_tag;
  assign ls_size_o      = 7'(PTE_BYTES);
  assign ls_req_irdy_o  = r_ls_req_irdy;
  assign ld_data_trdy_o = r_ld_trdy;
  assign stale_cnt_o    = r_stale_cnt;

endmodule

// File: tb/tb_rv_iommu_pte_fetch.sv
// Directed bench for rv_iommu_pte_fetch with hand-computed expectations.
module tb_rv_iommu_pte_fetch;

  logic         clk, rst_n;
  logic [45:0]  req_pte_addr_i;
  logic [3:0]   req_id_i;
  logic         req_irdy_i, req_trdy_o;
  logic [63:0]  rsp_pte_o;
  logic [3:0]   rsp_id_o;
  logic [1:0]   rsp_fault_o;
  logic         rsp_irdy_o, rsp_trdy_i;
  logic [45:0]  ls_addr_o;
  logic [1:0]   ls_op_o, ls_tag_o;
  logic [6:0]   ls_size_o;
  logic         ls_req_irdy_o, ls_req_trdy_i;
  logic [511:0] ld_data_i;
  logic         ld_acc_fault_i, ld_poison_i;
  logic [1:0]   ld_tag_i;
  logic         ld_data_irdy_i, ld_data_trdy_o;
  logic [7:0]   stale_cnt_o;

  int n_chk = 0;
  int n_fail = 0;

  rv_iommu_pte_fetch #(.ID_W(4), .TIMEOUT_CYC(1024), .STALE_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_pte_addr_i(req_pte_addr_i), .req_id_i(req_id_i),
    .req_irdy_i(req_irdy_i), .req_trdy_o(req_trdy_o),
    .rsp_pte_o(rsp_pte_o), .rsp_id_o(rsp_id_o), .rsp_fault_o(rsp_fault_o),
    .rsp_irdy_o(rsp_irdy_o), .rsp_trdy_i(rsp_trdy_i),
    .ls_addr_o(ls_addr_o), .ls_op_o(ls_op_o), .ls_tag_o(ls_tag_o),
    .ls_size_o(ls_size_o), .ls_req_irdy_o(ls_req_irdy_o), .ls_req_trdy_i(ls_req_trdy_i),
    .ld_data_i(ld_data_i), .ld_acc_fault_i(ld_acc_fault_i), .ld_poison_i(ld_poison_i),
    .ld_tag_i(ld_tag_i), .ld_data_irdy_i(ld_data_irdy_i), .ld_data_trdy_o(ld_data_trdy_o),
    .stale_cnt_o(stale_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [511:0] mk_line(input int w, input logic [63:0] v);
    logic [511:0] l;
    for (int i = 0; i < 8; i++) l[i*64 +: 64] = 64'hBAD0_0000_0000_0000 | 64'(i);
    l[w*64 +: 64] = v;
    return l;
  endfunction

  task automatic send_req(input logic [45:0] a, input logic [3:0] id);
    int n = 0;
    req_pte_addr_i = a; req_id_i = id; req_irdy_i = 1'b1;
    while (!req_trdy_o && n < 50) begin step(); n++; end
    n_chk++;
    if (req_trdy_o !== 1'b1) begin
      n_fail++; $display("FAIL req_accept_wait: req_trdy_o=%b required 1", req_trdy_o);
    end
    step();
    req_irdy_i = 1'b0;
  endtask

  task automatic send_ret(input logic [511:0] l, input logic [1:0] tag,
                          input logic acc, input logic poi);
    ld_data_i = l; ld_tag_i = tag; ld_acc_fault_i = acc; ld_poison_i = poi;
    ld_data_irdy_i = 1'b1;
    step();
    ld_data_irdy_i = 1'b0; ld_acc_fault_i = 1'b0; ld_poison_i = 1'b0;
  endtask

  task automatic ack_rsp();
    rsp_trdy_i = 1'b1; step(); rsp_trdy_i = 1'b0;
  endtask

  // Full fetch; checks the issued tag/addr and the resulting response.
  task automatic fetch(input string nm, input logic [45:0] a, input logic [3:0] id,
                       input logic [45:0] exp_addr, input logic [1:0] tag,
                       input int w, input logic [63:0] v, input logic acc, input logic poi,
                       input logic [63:0] exp_pte, input logic [1:0] exp_flt);
    send_req(a, id);
    n_chk++;
    if (ls_req_irdy_o !== 1'b1 || ls_tag_o !== tag || ls_addr_o !== exp_addr) begin
      n_fail++;
      $display("FAIL %s_issue: irdy=%b tag=%0d addr=%h required 1 %0d %h",
               nm, ls_req_irdy_o, ls_tag_o, ls_addr_o, tag, exp_addr);
    end
    step();
    send_ret(mk_line(w, v), tag, acc, poi);
    n_chk++;
    if (rsp_irdy_o !== 1'b1 || rsp_pte_o !== exp_pte || rsp_id_o !== id || rsp_fault_o !== exp_flt) begin
      n_fail++;
      $display("FAIL %s_rsp: irdy=%b pte=%h id=%0d flt=%0d required 1 %h %0d %0d",
               nm, rsp_irdy_o, rsp_pte_o, rsp_id_o, rsp_fault_o, exp_pte, id, exp_flt);
    end
    ack_rsp();
  endtask

  task automatic chk_reset_outs(input string nm);
    n_chk++;
    if (req_trdy_o !== 1'b0 || rsp_irdy_o !== 1'b0 || ls_req_irdy_o !== 1'b0 ||
        ld_data_trdy_o !== 1'b0 || rsp_pte_o !== 64'd0 || rsp_id_o !== 4'd0 ||
        rsp_fault_o !== 2'd0 || ls_addr_o !== 46'd0 || ls_tag_o !== 2'd0 ||
        stale_cnt_o !== 8'd0) begin
      n_fail++;
      $display("FAIL %s_zero: trdy=%b rirdy=%b lirdy=%b ldtrdy=%b pte=%h id=%0d flt=%0d addr=%h tag=%0d stale=%0d required all 0",
               nm, req_trdy_o, rsp_irdy_o, ls_req_irdy_o, ld_data_trdy_o, rsp_pte_o,
               rsp_id_o, rsp_fault_o, ls_addr_o, ls_tag_o, stale_cnt_o);
    end
    n_chk++;
    if (ls_op_o !== 2'd1 || ls_size_o !== 7'd8) begin
      n_fail++;
      $display("FAIL %s_const: op=%0d size=%0d required 1 8", nm, ls_op_o, ls_size_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    chk_reset_outs("reset");
    rst_n = 1'b1;
    step();
    n_chk++;
    if (req_trdy_o !== 1'b1 || ld_data_trdy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_ready: req_trdy=%b ld_trdy=%b required 1 1", req_trdy_o, ld_data_trdy_o);
    end
  endtask

  task automatic test_basic();
    fetch("word0", 46'h1000, 4'd3, 46'h1000, 2'd0, 0, 64'h2001, 1'b0, 1'b0, 64'h2001, 2'd0);
    fetch("word1", 46'h3048, 4'd5, 46'h3048, 2'd1, 1, 64'h4001, 1'b0, 1'b0, 64'h4001, 2'd0);
  endtask

  task automatic test_faults();
    fetch("acc_poison", 46'h2010, 4'd7, 46'h2010, 2'd2, 2, 64'h1234, 1'b1, 1'b1, 64'd0, 2'd1);
    fetch("poison", 46'h2018, 4'd8, 46'h2018, 2'd3, 3, 64'h5678, 1'b0, 1'b1, 64'd0, 2'd2);
    // Low address bits dropped; 0x10FE selects doubleword 7 and the tag wraps to 0.
    fetch("word7_wrap", 46'h10FE, 4'd15, 46'h10F8, 2'd0, 7, 64'hFEED_0000_0000_0007,
          1'b0, 1'b0, 64'hFEED_0000_0000_0007, 2'd0);
  endtask

  task automatic test_timeout();
    int n = 0;
    send_req(46'h5000, 4'd9);
    step();
    while (!rsp_irdy_o && n < 2000) begin step(); n++; end
    n_chk++;
    if (n !== 1024) begin
      n_fail++; $display("FAIL timeout_cycles: waited=%0d required 1024", n);
    end
    n_chk++;
    if (rsp_irdy_o !== 1'b1 || rsp_fault_o !== 2'd3 || rsp_pte_o !== 64'd0 || rsp_id_o !== 4'd9) begin
      n_fail++;
      $display("FAIL timeout_rsp: irdy=%b flt=%0d pte=%h id=%0d required 1 3 0 9",
               rsp_irdy_o, rsp_fault_o, rsp_pte_o, rsp_id_o);
    end
    ack_rsp();
    send_req(46'h6008, 4'd2);
    n_chk++;
    if (ls_tag_o !== 2'd2) begin
      n_fail++; $display("FAIL after_timeout_tag: tag=%0d required 2", ls_tag_o);
    end
    step();
    send_ret(mk_line(1, 64'h7777), 2'd1, 1'b0, 1'b0);
    n_chk++;
    if (stale_cnt_o !== 8'd1 || rsp_irdy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL late_return: stale=%0d rsp_irdy=%b required 1 0", stale_cnt_o, rsp_irdy_o);
    end
    send_ret(mk_line(1, 64'h8001), 2'd2, 1'b0, 1'b0);
    n_chk++;
    if (rsp_irdy_o !== 1'b1 || rsp_pte_o !== 64'h8001 || rsp_fault_o !== 2'd0 || rsp_id_o !== 4'd2) begin
      n_fail++;
      $display("FAIL after_stale_rsp: irdy=%b pte=%h flt=%0d id=%0d required 1 8001 0 2",
               rsp_irdy_o, rsp_pte_o, rsp_fault_o, rsp_id_o);
    end
    ack_rsp();
  endtask

  task automatic test_backpressure();
    send_req(46'h7020, 4'd6);
    step();
    send_ret(mk_line(4, 64'hABCD), 2'd3, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (rsp_irdy_o !== 1'b1 || rsp_pte_o !== 64'hABCD || rsp_id_o !== 4'd6 ||
          rsp_fault_o !== 2'd0 || req_trdy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_%0d: irdy=%b pte=%h id=%0d flt=%0d req_trdy=%b required 1 abcd 6 0 0",
                 i, rsp_irdy_o, rsp_pte_o, rsp_id_o, rsp_fault_o, req_trdy_o);
      end
      if (i == 2) send_ret(mk_line(4, 64'h9999), 2'd3, 1'b0, 1'b0);
      else step();
    end
    n_chk++;
    if (stale_cnt_o !== 8'd2) begin
      n_fail++; $display("FAIL rsp_state_return: stale=%0d required 2", stale_cnt_o);
    end
    ack_rsp();
    n_chk++;
    if (rsp_irdy_o !== 1'b0 || req_trdy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: rsp_irdy=%b req_trdy=%b required 0 1", rsp_irdy_o, req_trdy_o);
    end
  endtask

  task automatic test_reset_mid();
    fetch("pre_rst", 46'h8000, 4'd1, 46'h8000, 2'd0, 0, 64'h1111, 1'b0, 1'b0, 64'h1111, 2'd0);
    send_req(46'h9008, 4'd4);
    step();
    rst_n = 1'b0;
    step();
    chk_reset_outs("mid_reset");
    rst_n = 1'b1;
    repeat (3) step();
    n_chk++;
    if (rsp_irdy_o !== 1'b0) begin
      n_fail++; $display("FAIL no_rsp_after_reset: rsp_irdy=%b required 0", rsp_irdy_o);
    end
    fetch("post_rst", 46'h9010, 4'd12, 46'h9010, 2'd0, 2, 64'h2222, 1'b0, 1'b0, 64'h2222, 2'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_pte_addr_i = '0; req_id_i = '0; req_irdy_i = 1'b0;
    rsp_trdy_i = 1'b0; ls_req_trdy_i = 1'b1;
    ld_data_i = '0; ld_acc_fault_i = 1'b0; ld_poison_i = 1'b0;
    ld_tag_i = '0; ld_data_irdy_i = 1'b0;
    test_reset();
    test_basic();
    test_faults();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
